alu_op_scheduler: RTL and testbench
===================================

// Module: alu_op_scheduler
// PURPOSE
//  Shares one ALU_reconfig instance between NREQ requesters. Each requester has a valid/ready request channel.
//  Requesters are granted round-robin. The block drives the ALU's en/A/B/opcode, waits the ALU latency and
//  captures out/Cout_1/ouflag. The result returns on one response channel, tagged with the requester ID.
//  It sits between the operand producers and the ALU; the ALU itself stays unchanged.
// PARAMETERS
//  NREQ         2  number of requesters (>=2)
//  DATA_W       8  operand width; result width is 2*DATA_W
//  OPC_W        4  opcode width, passed to ALU unchanged
//  ALU_LATENCY  1  clock edges from alu_en/operands valid to alu_out valid (>=1)
// PORTS
//  clk         in   1             clock, rising edge
//  reset       in   1             async, active-low reset
//  req_valid   in   NREQ          per-requester request valid
//  req_ready   out  NREQ          per-requester accept, at most one bit high
//  req_a       in   NREQ*DATA_W   operand A, requester i at [i*DATA_W +: DATA_W]
//  req_b       in   NREQ*DATA_W   operand B, same packing
//  req_opcode  in   NREQ*OPC_W    opcode, same packing
//  rsp_valid   out  1             response valid
//  rsp_ready   in   1             response accept
//  rsp_id      out  $clog2(NREQ)  requester index of response
//  rsp_out     out  2*DATA_W      captured alu_out
//  rsp_cout    out  1             captured alu_cout
//  rsp_ouflag  out  1             captured alu_ouflag
//  alu_en      out  1             ALU enable
//  alu_a/alu_b out  DATA_W        ALU operands
//  alu_opcode  out  OPC_W         ALU opcode
//  alu_out     in   2*DATA_W      ALU result
//  alu_cout    in   1             ALU carry out
//  alu_ouflag  in   1             ALU over/underflow flag
//  busy        out  1             state != IDLE
// BEHAVIOUR
//  Reset (reset==0, async):
//   - state=IDLE; all outputs 0; operand/result regs 0; cnt=0.
//   - last_grant=NREQ-1, so requester 0 has first priority.
//  FSM IDLE -> EXEC -> RESP -> IDLE:
//   - IDLE: if any req_valid, the arbiter picks the first valid index searching from last_grant+1 (mod NREQ).
//     req_ready[g]=1 combinationally in that cycle only. On the edge: latch a/b/opcode of g, id=g,
//     last_grant=g, cnt=0, go to EXEC. No valid requests -> stay in IDLE, req_ready=0.
//   - EXEC: alu_en=1, alu_a/b/opcode = latched values, held stable for ALU_LATENCY+1 cycles.
//     cnt increments each cycle. At the edge where cnt==ALU_LATENCY: capture alu_out/cout/ouflag
//     into rsp regs, drop alu_en, go to RESP.
//   - RESP: rsp_valid=1; rsp_* stable until rsp_ready. On rsp_valid&&rsp_ready go to IDLE.
//     No new request is accepted in that same cycle.
//  Timing and throughput:
//   - Accept at cycle 0 -> alu_en cycles 1..ALU_LATENCY+1 -> rsp_valid from cycle ALU_LATENCY+2.
//   - Max throughput: one op per ALU_LATENCY+3 cycles.
//  Requester rules:
//   - Payload must be held stable while req_valid=1 and not accepted.
//   - Dropping req_valid before accept is legal; nothing is issued.
//   - req_ready=0 in EXEC and RESP regardless of req_valid.
//  Datapath rules:
//   - Opcode is not decoded; unknown opcodes pass through and the result is whatever the ALU returns.
//   - No width conversion: operands are passed as-is; results are captured at full 2*DATA_W.
//   - alu_a/b/opcode keep their last value outside EXEC; only alu_en qualifies them.
//  Reset mid-operation: in-flight op discarded, no response produced, arbitration pointer returns to reset value.
//  rsp_ready held high with no response pending: ignored.
// STRUCTURE
//  Package alu_sched_pkg:
//   - DATA_W/OPC_W defaults.
//   - OP_ADD=4'b1111, OP_SUB=4'b1110.
//   - typedef enum logic[1:0] {IDLE,EXEC,RESP} sched_state_t.
//  Sub-module rr_arbiter #(NREQ):
//   - Combinational one-hot grant from req and last_grant, plus grant index.
//   - Pointer register stays in the parent.
//  Remainder: FSM, latency counter, operand/result registers. Target ~200 lines.
// TESTING (bench instantiates alu_op_scheduler + ALU_reconfig, ALU_LATENCY=1)
//  1. Req0 A=8'hAA B=8'h55 op=1111 -> rsp_out=16'h00FF, rsp_id=0, rsp_valid exactly 3 cycles after accept.
//  2. Req1 A=8'hAA B=8'h55 op=1110 -> rsp_out=16'h0055, rsp_id=1; req_ready stays 0 in EXEC/RESP.
//  3. Both req_valid held for 4 ops -> grant order 0,1,0,1. Each response id matches its grant and the right sum/difference.
//  4. rsp_ready=0 for 5 cycles in RESP -> rsp_* stable; busy=1; no req_ready; accept resumes the cycle after handshake.
//  5. reset pulsed low mid-EXEC -> alu_en=0 and rsp_valid=0 immediately. No stale response. Next simultaneous request grants req0.
//  6. Rerun 1 with ALU_LATENCY=3 and a delayed ALU model -> alu_en high 4 cycles; rsp_valid 5 cycles after accept.

Source files
------------

// File: rtl/alu_op_scheduler_pkg.sv
// Shared types and constants for the ALU operation scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_sched_pkg;

  // Default operand and opcode widths of the shared ALU.
  localparam int DATA_W_DEF = 8;
  localparam int OPC_W_DEF  = 4;

  // Opcodes that the operand producers commonly issue; the scheduler never decodes them.
  localparam logic [3:0] OP_ADD = 4'b1111;
  localparam logic [3:0] OP_SUB = 4'b1110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_t;

endpackage

// File: rtl/alu_op_scheduler_arb.sv
// Round-robin arbiter: one-hot grant for the first requester after last_grant_i.
// Latency: purely combinational; the pointer register lives in the parent.
// Backpressure: none; grant_vld_o is low when no requester is valid.
// Ports: req_i (request vector), last_grant_i (previous winner),
//        grant_o (one-hot), grant_idx_o (binary winner), grant_vld_o (any grant).
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] last_grant_i,
  output logic [NREQ-1:0]  grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             grant_vld_o
);

  int cand;

  // Walk the requesters starting one past the previous winner; the first valid one wins.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    grant_vld_o = 1'b0;
    cand        = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_grant_i) + k) % NREQ;
      if (!grant_vld_o && req_i[cand]) begin
        grant_vld_o   = 1'b1;
        grant_idx_o   = IDX_W'(cand);
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares one ALU between NREQ requesters, round-robin, returning ID-tagged results.
// Latency: accept at cycle 0, alu_en cycles 1..ALU_LATENCY+1, rsp_valid from cycle ALU_LATENCY+2.
// Backpressure: rsp_ready low holds the response; no request is accepted until it is taken.
// Ports: clk/reset (async, active low); req_* per-requester request channels (packed by index);
//        rsp_* response channel; alu_* drive/capture of the shared ALU; busy = not idle.
module alu_op_scheduler
  import alu_sched_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int OPC_W       = OPC_W_DEF,
  parameter int ALU_LATENCY = 1,
  localparam int IDX_W      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  input  logic [NREQ*OPC_W-1:0]  req_opcode,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDX_W-1:0]       rsp_id,
  output logic [2*DATA_W-1:0]    rsp_out,
  output logic                   rsp_cout,
  output logic                   rsp_ouflag,
  output logic                   alu_en,
  output logic [DATA_W-1:0]      alu_a,
  output logic [DATA_W-1:0]      alu_b,
  output logic [OPC_W-1:0]       alu_opcode,
  input  logic [2*DATA_W-1:0]    alu_out,
  input  logic                   alu_cout,
  input  logic                   alu_ouflag,
  output logic                   busy
);

  localparam int CNT_W = (ALU_LATENCY > 0) ? $clog2(ALU_LATENCY + 1) : 1;

  sched_state_t         state_q, state_d;
  logic [IDX_W-1:0]     last_grant_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [DATA_W-1:0]    a_q, b_q;
  logic [OPC_W-1:0]     opc_q;
  logic [IDX_W-1:0]     id_q;
  logic [2*DATA_W-1:0]  out_q;
  logic                 cout_q, ouflag_q;

  logic [NREQ-1:0]      grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_vld;
  logic                 accept;
  logic                 exec_done;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx),
    .grant_vld_o  (grant_vld)
  );

  assign accept    = (state_q == IDLE) && grant_vld;
  assign exec_done = (state_q == EXEC) && (cnt_q == CNT_W'(ALU_LATENCY));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_vld) state_d = EXEC;
      EXEC:    if (exec_done) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs; the grant is only exposed while idle, so at most one ready bit is high.
  always_comb begin
    req_ready = (state_q == IDLE) ? grant : '0;
    alu_en    = (state_q == EXEC);
    rsp_valid = (state_q == RESP);
    busy      = (state_q != IDLE);
  end

  // Operand latch, latency counter, result capture and arbitration pointer.
  // Operands are not cleared after an op: alu_en alone qualifies them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= IDX_W'(NREQ - 1);
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      opc_q        <= '0;
      id_q         <= '0;
      out_q        <= '0;
      cout_q       <= 1'b0;
      ouflag_q     <= 1'b0;
    end else begin
      if (accept) begin
        a_q          <= req_a[grant_idx*DATA_W +: DATA_W];
        b_q          <= req_b[grant_idx*DATA_W +: DATA_W];
        opc_q        <= req_opcode[grant_idx*OPC_W +: OPC_W];
        id_q         <= grant_idx;
        last_grant_q <= grant_idx;
        cnt_q        <= '0;
      end
      if (state_q == EXEC) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (exec_done) begin
        out_q    <= alu_out;
        cout_q   <= alu_cout;
        ouflag_q <= alu_ouflag;
      end
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_opcode = opc_q;
  assign rsp_id     = id_q;
  assign rsp_out    = out_q;
  assign rsp_cout   = cout_q;
  assign rsp_ouflag = ouflag_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Bench for alu_op_scheduler with behavioural ALU stand-ins at latency 1 and 3.
// Latency: n/a.
// Backpressure: n/a.
module tb_alu_op_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ALU stand-in: 1111 add, 1110 subtract, anything else returns {a,b}.
  // Packed as {ouflag, cout, out[15:0]}.
  function automatic logic [17:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    logic [8:0] s;
    logic       ov;
    case (op)
      4'b1111: begin
        s  = {1'b0, a} + {1'b0, b};
        ov = (a[7] == b[7]) && (s[7] != a[7]);
        return {ov, s[8], 8'h00, s[7:0]};
      end
      4'b1110: begin
        s  = {1'b0, a} - {1'b0, b};
        ov = (a[7] != b[7]) && (s[7] != a[7]);
        return {ov, s[8], 8'h00, s[7:0]};
      end
      default: return {2'b00, a, b};
    endcase
  endfunction

  // ---------------- instance with ALU_LATENCY=1 ----------------
  logic [1:0]  req_valid, req_ready;
  logic [15:0] req_a, req_b;
  logic [7:0]  req_opcode;
  logic        rsp_valid, rsp_ready, rsp_cout, rsp_ouflag;
  logic [0:0]  rsp_id;
  logic [15:0] rsp_out;
  logic        alu_en, busy;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_opcode;
  logic [17:0] alu_r = '0;

  always_ff @(posedge clk) if (alu_en) alu_r <= alu_f(alu_a, alu_b, alu_opcode);

  alu_op_scheduler #(.NREQ(2), .DATA_W(8), .OPC_W(4), .ALU_LATENCY(1)) u_dut (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_cout(rsp_cout), .rsp_ouflag(rsp_ouflag),
    .alu_en(alu_en), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_out(alu_r[15:0]), .alu_cout(alu_r[16]), .alu_ouflag(alu_r[17]),
    .busy(busy)
  );

  // ---------------- instance with ALU_LATENCY=3 ----------------
  logic [1:0]  b_req_valid, b_req_ready;
  logic [15:0] b_req_a, b_req_b;
  logic [7:0]  b_req_opcode;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_cout, b_rsp_ouflag;
  logic [0:0]  b_rsp_id;
  logic [15:0] b_rsp_out;
  logic        b_alu_en, b_busy;
  logic [7:0]  b_alu_a, b_alu_b;
  logic [3:0]  b_alu_opcode;
  logic [17:0] b_p1 = '0, b_p2 = '0, b_p3 = '0;

  always_ff @(posedge clk) begin
    b_p1 <= alu_f(b_alu_a, b_alu_b, b_alu_opcode);
    b_p2 <= b_p1;
    b_p3 <= b_p2;
  end

  alu_op_scheduler #(.NREQ(2), .DATA_W(8), .OPC_W(4), .ALU_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_a(b_req_a), .req_b(b_req_b), .req_opcode(b_req_opcode),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id),
    .rsp_out(b_rsp_out), .rsp_cout(b_rsp_cout), .rsp_ouflag(b_rsp_ouflag),
    .alu_en(b_alu_en), .alu_a(b_alu_a), .alu_b(b_alu_b), .alu_opcode(b_alu_opcode),
    .alu_out(b_p3[15:0]), .alu_cout(b_p3[16]), .alu_ouflag(b_p3[17]),
    .busy(b_busy)
  );

  // One cycle: advance to the next falling edge and let combinational outputs settle.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Wait (bounded) until req_ready shows the wanted grant; reports cycles waited.
  task automatic wait_accept(input logic [1:0] want, output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready === want) begin
        ok = 1'b1;
        waited = i;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; req_opcode = '0; rsp_ready = 1'b0;
    b_req_valid = '0; b_req_a = '0; b_req_b = '0; b_req_opcode = '0; b_rsp_ready = 1'b0;
    #3;
    checks++;
    if ({busy, alu_en, rsp_valid, req_ready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got busy/en/rsp_valid/ready=%b required 00000", {busy, alu_en, rsp_valid, req_ready});
    end
    checks++;
    if ({rsp_out, alu_a, alu_b, alu_opcode, rsp_id} !== '0) begin
      errors++;
      $display("FAIL reset_data: got rsp_out=%h alu_a=%h alu_b=%h opc=%h id=%h required all 0", rsp_out, alu_a, alu_b, alu_opcode, rsp_id);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_add();
    bit ok;
    int w;
    req_a[7:0] = 8'hAA; req_b[7:0] = 8'h55; req_opcode[3:0] = 4'b1111;
    req_valid = 2'b01;
    #1;
    wait_accept(2'b01, ok, w);
    checks++;
    if (!ok) begin errors++; $display("FAIL add_accept: req_ready=%b required 01", req_ready); end
    step();
    req_valid = 2'b00;
    checks++;
    if ({alu_en, alu_a, alu_b, alu_opcode, rsp_valid} !== {1'b1, 8'hAA, 8'h55, 4'b1111, 1'b0}) begin
      errors++;
      $display("FAIL add_cycle1: got en=%b a=%h b=%h op=%b rsp_valid=%b required 1 aa 55 1111 0", alu_en, alu_a, alu_b, alu_opcode, rsp_valid);
    end
    step();
    checks++;
    if ({alu_en, rsp_valid} !== 2'b10) begin
      errors++; $display("FAIL add_cycle2: got en/rsp_valid=%b required 10", {alu_en, rsp_valid});
    end
    step();
    checks++;
    if ({rsp_valid, alu_en, rsp_id, rsp_out, rsp_cout, rsp_ouflag} !== {1'b1, 1'b0, 1'b0, 16'h00FF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL add_rsp: got valid=%b en=%b id=%0d out=%h cout=%b of=%b required 1 0 0 00ff 0 0", rsp_valid, alu_en, rsp_id, rsp_out, rsp_cout, rsp_ouflag);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, busy, alu_en, alu_a} !== {3'b000, 8'hAA}) begin
      errors++; $display("FAIL add_after: got valid/busy/en=%b alu_a=%h required 000 aa", {rsp_valid, busy, alu_en}, alu_a);
    end
  endtask

  task automatic test_single_sub();
    bit ok;
    int w;
    req_a[15:8] = 8'hAA; req_b[15:8] = 8'h55; req_opcode[7:4] = 4'b1110;
    req_valid = 2'b10;
    #1;
    wait_accept(2'b10, ok, w);
    checks++;
    if (!ok) begin errors++; $display("FAIL sub_accept: req_ready=%b required 10", req_ready); end
    step();
    req_valid = 2'b11;   // req0 now also waits: must not be readied during EXEC/RESP
    #1;
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (req_ready !== 2'b00) begin
        errors++; $display("FAIL sub_no_ready_c%0d: req_ready=%b required 00", c, req_ready);
      end
      if (c < 3) step();
    end
    checks++;
    if ({rsp_valid, rsp_id, rsp_out, rsp_cout, rsp_ouflag} !== {1'b1, 1'b1, 16'h0055, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL sub_rsp: got valid=%b id=%0d out=%h cout=%b of=%b required 1 1 0055 0 1", rsp_valid, rsp_id, rsp_out, rsp_cout, rsp_ouflag);
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [15:0] exp_o [4] = '{16'h0013, 16'h001B, 16'h0013, 16'h001B};
    bit ok;
    int w;
    req_a = {8'h20, 8'h10}; req_b = {8'h05, 8'h03}; req_opcode = {4'b1110, 4'b1111};
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #1;
    for (int n = 0; n < 4; n++) begin
      wait_accept(exp_g[n], ok, w);
      checks++;
      if (!ok || (n > 0 && w != 0)) begin
        errors++; $display("FAIL b2b_grant%0d: req_ready=%b waited=%0d required %b with no wait", n, req_ready, w, exp_g[n]);
      end
      step(); step(); step();
      if (n == 3) req_valid = 2'b00;
      checks++;
      if ({rsp_valid, rsp_id, rsp_out} !== {1'b1, exp_g[n][1], exp_o[n]}) begin
        errors++;
        $display("FAIL b2b_rsp%0d: got valid=%b id=%0d out=%h required 1 %0d %h", n, rsp_valid, rsp_id, rsp_out, exp_g[n][1], exp_o[n]);
      end
      step();
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    int w;
    req_a[15:8] = 8'h0F; req_b[15:8] = 8'hF0; req_opcode[7:4] = 4'b0011;  // undecoded opcode
    req_valid = 2'b10;
    #1;
    wait_accept(2'b10, ok, w);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_accept: req_ready=%b required 10", req_ready); end
    step();
    req_valid = 2'b11;
    step(); step();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({rsp_valid, rsp_id, rsp_out, busy, req_ready} !== {1'b1, 1'b1, 16'h0FF0, 1'b1, 2'b00}) begin
        errors++;
        $display("FAIL bp_hold%0d: got valid=%b id=%0d out=%h busy=%b ready=%b required 1 1 0ff0 1 00", c, rsp_valid, rsp_id, rsp_out, busy, req_ready);
      end
      step();
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_hs_cycle: req_ready=%b required 00", req_ready); end
    step();
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_resume: req_ready=%b required 01", req_ready); end
    req_valid = 2'b00;   // withdraw before the edge: nothing may be issued
    step();
    checks++;
    if ({busy, alu_en} !== 2'b00) begin errors++; $display("FAIL bp_withdraw: busy/en=%b required 00", {busy, alu_en}); end
  endtask

  task automatic test_reset_mid_exec();
    bit ok;
    bit seen;
    int w;
    req_a[7:0] = 8'h11; req_b[7:0] = 8'h22; req_opcode[3:0] = 4'b1111;
    req_valid = 2'b01;
    #1;
    wait_accept(2'b01, ok, w);
    step();
    req_valid = 2'b00;
    checks++;
    if (!ok || alu_en !== 1'b1) begin errors++; $display("FAIL rst_pre: ok=%b alu_en=%b required 1 1", ok, alu_en); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({alu_en, rsp_valid, busy} !== 3'b000) begin
      errors++; $display("FAIL rst_async: en/rsp_valid/busy=%b required 000", {alu_en, rsp_valid, busy});
    end
    step();
    rst_n = 1'b1;
    rsp_ready = 1'b1;   // held high with nothing pending: ignored
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      step();
    end
    checks++;
    if (seen) begin errors++; $display("FAIL rst_stale: response or busy seen after reset, required none"); end
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_ptr: req_ready=%b required 01", req_ready); end
    step();
    req_valid = 2'b00;
    step(); step();
    checks++;
    if ({rsp_valid, rsp_id, rsp_out} !== {1'b1, 1'b0, 16'h0033}) begin
      errors++; $display("FAIL rst_next_rsp: valid=%b id=%0d out=%h required 1 0 0033", rsp_valid, rsp_id, rsp_out);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_latency3();
    bit ok;
    int en_cnt;
    int first_rsp;
    b_req_a[7:0] = 8'hAA; b_req_b[7:0] = 8'h55; b_req_opcode[3:0] = 4'b1111;
    b_req_valid = 2'b01;
    #1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (b_req_ready === 2'b01) begin ok = 1'b1; break; end
      step();
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL l3_accept: req_ready=%b required 01", b_req_ready); end
    en_cnt = 0;
    first_rsp = -1;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) b_req_valid = 2'b00;
      if (b_alu_en === 1'b1) en_cnt++;
      if (first_rsp < 0 && b_rsp_valid === 1'b1) first_rsp = c;
    end
    checks++;
    if (en_cnt != 4) begin errors++; $display("FAIL l3_en_cycles: got %0d required 4", en_cnt); end
    checks++;
    if (first_rsp != 5) begin errors++; $display("FAIL l3_rsp_delay: got %0d required 5", first_rsp); end
    checks++;
    if ({b_rsp_valid, b_rsp_id, b_rsp_out, b_rsp_cout, b_rsp_ouflag} !== {1'b1, 1'b0, 16'h00FF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL l3_rsp: valid=%b id=%0d out=%h cout=%b of=%b required 1 0 00ff 0 0", b_rsp_valid, b_rsp_id, b_rsp_out, b_rsp_cout, b_rsp_ouflag);
    end
    b_rsp_ready = 1'b1;
    step();
    b_rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_single_sub();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_exec();
    test_latency3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
